cory_burst_drain: RTL and testbench
===================================

# cory_burst_drain

Burst-forming drain stage placed directly downstream of a count-reporting queue. It watches the queue's occupancy count and releases entries in bursts of fixed length B, with a marked last beat. Partial bursts are released only after a timeout or on an explicit flush. It converts a trickle of single transfers into framed bursts for a burst-oriented consumer such as a memory write port or a packetiser.

## Interface
- N, 8, data width
- B, 4, full burst length in beats; 1 ≤ B ≤ 2^MQ
- MQ, 2, count field parameter; the count input is MQ+1 bits wide, matching the upstream queue's count output
- T, 16, partial-burst timeout in cycles; T ≥ 1
- MT, derived, ceil(log2(T+1)), width of the wait counter

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- i_a_v  in  1  upstream valid
- i_a_d  in  N  upstream data
- o_a_r  out  1  upstream ready (pop)
- i_a_cnt  in  MQ+1  upstream queue occupancy
- i_flush  in  1  level request: release any partial burst at the next decision point
- o_z_v  out  1  downstream valid
- o_z_d  out  N  downstream data
- o_z_last  out  1  last beat of current burst
- o_z_len  out  MQ+1  length of current burst; held after the burst ends
- i_z_r  in  1  downstream ready

## Operation
- Two states: IDLE and BURST. Registered state `len` (MQ+1 bits), beat counter `beat` (MQ+1 bits), wait counter `wcnt` (MT bits).
- IDLE outputs: o_z_v=0, o_a_r=0, o_z_last=0.
- IDLE decisions are evaluated each cycle, in priority order:
  - i_a_cnt ≥ B → go BURST with len=B.
  - else i_a_cnt > 0 and (i_flush or wcnt == T-1) → go BURST with len=i_a_cnt.
  - else i_a_cnt > 0 → wcnt += 1.
  - else (i_a_cnt == 0) → wcnt=0.
- On any transition to BURST: wcnt=0, beat=0, o_z_len=len.
- BURST outputs: o_z_v=i_a_v, o_z_d=i_a_d, o_a_r=i_z_r, o_z_last = (beat == len-1).
- Beat handling in BURST:
  - A beat transfers when o_z_v & i_z_r; then beat += 1.
  - A transfer with o_z_last=1 returns the block to IDLE.
- Only this block pops the queue, so i_a_cnt cannot fall while in IDLE. The captured len is therefore guaranteed to be present. i_a_v low during BURST is a stall, not an error: no beat is counted.
- Arithmetic and width rules:
  - Comparisons are unsigned and use MQ+1 bits.
  - wcnt saturates at T-1; it never wraps.
  - beat never exceeds len-1.
- i_flush is ignored when i_a_cnt == 0 and ignored during BURST; it is sampled again in IDLE.

## Timing
- Reset values: state IDLE; len, beat, wcnt, o_z_len = 0; o_z_v, o_z_last, o_a_r = 0; o_z_d follows i_a_d (don't-care).
- Decision to first beat: a decision in IDLE at cycle k puts o_z_v high at cycle k+1 at the earliest.
- Full bursts: with ≥B entries present and i_z_r=1, there is one IDLE cycle between bursts. Sustained rate is B beats per B+1 cycles.
- Timeout: if i_a_cnt becomes nonzero (and stays <B) at cycle c in IDLE, the decision is taken at c+T-1 and the first beat appears at c+T. For T=1 the first beat appears at c+1.
- Flush: i_flush high at cycle c in IDLE with i_a_cnt>0 → first beat at c+1.
- Simultaneous full count and flush: the full burst (len=B) wins.
- o_a_r depends combinationally on i_z_r only in BURST. There is no combinational path from i_a_cnt to any output.
- Reset asserted mid-burst: the block returns to IDLE immediately. The partial burst is abandoned without o_z_last; remaining entries stay in the queue.

## Test plan
- B=4, T=16: push 8 entries (values 1..8) into the queue, i_z_r=1 → two bursts [1,2,3,4] and [5,6,7,8], o_z_last on 4 and 8, o_z_len=4, one idle cycle between the bursts.
- Push 2 entries at cycle c, no more input, no flush → first beat at c+16, o_z_len=2, o_z_last on the 2nd beat; the queue count returns to 0.
- 3 entries present, i_flush pulsed at cycle c → 3-beat burst starting at c+1, o_z_len=3.
- Full 4-beat burst with i_z_r toggling 1,0,1,0 → 4 beats delivered in order, beat counter stalls on i_z_r=0 cycles, o_z_last held until accepted.
- Count reaches 4 in the same cycle i_flush=1 and the wait counter is at T-1 → len=4 chosen, wait counter cleared to 0.
- reset_n asserted after beat 2 of a 4-beat burst → o_z_v=0 while in reset; after release, state is IDLE and o_z_len=0.

Source files
------------

// File: rtl/cory_burst_drain.sv
// Burst-forming drain stage: watches an upstream queue's occupancy and releases
// its entries downstream in framed bursts of B beats, or shorter on timeout/flush.
module cory_burst_drain #(
  parameter int N  = 8,
  parameter int B  = 4,
  parameter int MQ = 2,
  parameter int T  = 16,
  localparam int MT = $clog2(T + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_a_v,
  input  logic [N-1:0]  i_a_d,
  output logic          o_a_r,
  input  logic [MQ:0]   i_a_cnt,
  input  logic          i_flush,
  output logic          o_z_v,
  output logic [N-1:0]  o_z_d,
  output logic          o_z_last,
  output logic [MQ:0]   o_z_len,
  input  logic          i_z_r
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam int TM1_I = T - 1;
  localparam logic [MQ:0]   B_C  = B[MQ:0];
  localparam logic [MQ:0]   ONE  = {{MQ{1'b0}}, 1'b1};
  localparam logic [MT-1:0] TM1  = TM1_I[MT-1:0];
  localparam logic [MT-1:0] WONE = {{(MT-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [MQ:0]   len_q, len_d;
  logic [MQ:0]   beat_q, beat_d;
  logic [MT-1:0] wcnt_q, wcnt_d;
  logic          last;

  // len_q doubles as the reported burst length; it is only rewritten on entry to BURST.
  assign o_z_len = len_q;
  assign o_z_d   = i_a_d;
  assign last    = (beat_q == len_q - ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    beat_d   = beat_q;
    wcnt_d   = wcnt_q;
    o_z_v    = 1'b0;
    o_a_r    = 1'b0;
    o_z_last = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Full burst outranks flush/timeout when both apply in the same cycle.
        if (i_a_cnt >= B_C) begin
          state_d = S_BURST;
          len_d   = B_C;
          beat_d  = '0;
          wcnt_d  = '0;
        end else if ((i_a_cnt != '0) && (i_flush || (wcnt_q == TM1))) begin
          state_d = S_BURST;
          len_d   = i_a_cnt;
          beat_d  = '0;
          wcnt_d  = '0;
        end else if (i_a_cnt != '0) begin
          if (wcnt_q != TM1) wcnt_d = wcnt_q + WONE;
        end else begin
          wcnt_d = '0;
        end
      end
      S_BURST: begin
        o_z_v    = i_a_v;
        o_a_r    = i_z_r;
        o_z_last = last;
        if (i_a_v && i_z_r) begin
          if (last) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cory_burst_drain.sv
// Self-checking bench for cory_burst_drain: a queue model drives the DUT, and a
// transaction-level burst model predicts framing, lengths and data order.
module tb_cory_burst_drain;
  localparam int N = 8, B = 4, MQ = 2, T = 16, DEPTH = 7;

  logic          clk, reset_n;
  logic          i_a_v, o_a_r, i_flush, o_z_v, o_z_last, i_z_r;
  logic [N-1:0]  i_a_d, o_z_d;
  logic [MQ:0]   i_a_cnt, o_z_len;

  cory_burst_drain #(.N(N), .B(B), .MQ(MQ), .T(T)) dut (
    .clk(clk), .reset_n(reset_n), .i_a_v(i_a_v), .i_a_d(i_a_d), .o_a_r(o_a_r),
    .i_a_cnt(i_a_cnt), .i_flush(i_flush), .o_z_v(o_z_v), .o_z_d(o_z_d),
    .o_z_last(o_z_last), .o_z_len(o_z_len), .i_z_r(i_z_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [N-1:0] q[$];
  logic [N-1:0] pushed[$];
  int rd_idx = 0, push_val = 1, cyc = 0;
  // burst model: busy flag, beats still owed, reported length, idle cycles with data waiting
  bit m_busy = 0;
  int m_left = 0, m_zlen = 0, m_wait = 0;
  int fire_d[$], fire_last[$], fire_cyc[$];
  int last_stall = 0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_start(input int n);
    m_busy = 1; m_left = n; m_zlen = n; m_wait = 0;
  endtask

  task automatic clear_log();
    fire_d.delete(); fire_last.delete(); fire_cyc.delete(); last_stall = 0;
  endtask

  task automatic step(input int npush, input bit flush, input bit zr);
    bit popped;
    int cnt;
    for (int k = 0; k < npush; k++)
      if (q.size() < DEPTH) begin
        q.push_back(push_val[N-1:0]); pushed.push_back(push_val[N-1:0]); push_val++;
      end
    i_a_v   = (q.size() != 0);
    i_a_d   = (q.size() != 0) ? q[0] : '0;
    i_a_cnt = (MQ+1)'(q.size());
    i_flush = flush;
    i_z_r   = zr;
    @(negedge clk);
    chk("z_v",    o_z_v,    m_busy ? int'(i_a_v) : 0);
    chk("a_r",    o_a_r,    m_busy ? int'(i_z_r) : 0);
    chk("z_last", o_z_last, (m_busy && m_left == 1) ? 1 : 0);
    chk("z_len",  o_z_len,  m_zlen);
    if (o_z_v && i_z_r) begin
      fire_d.push_back(o_z_d); fire_last.push_back(o_z_last); fire_cyc.push_back(cyc);
    end
    if (o_z_v && o_z_last && !i_z_r) last_stall++;
    popped = o_a_r && i_a_v;
    cnt = q.size();
    if (m_busy) begin
      if (i_a_v && i_z_r) begin
        if (rd_idx < pushed.size()) chk("z_d", o_z_d, pushed[rd_idx]);
        rd_idx++;
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end else if (cnt >= B) model_start(B);
    else if (cnt > 0 && (flush || m_wait == T-1)) model_start(cnt);
    else if (cnt > 0) m_wait = (m_wait + 1 > T-1) ? T-1 : m_wait + 1;
    else m_wait = 0;
    @(posedge clk); #1;
    if (popped && q.size() != 0) void'(q.pop_front());
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || m_busy) && n < 300) begin step(0, 0, 1); n++; end
    if (n >= 300) chk("drain_bound", 1, 0);
  endtask

  task automatic wait_fire(input string tag);
    int n = 0;
    while (fire_cyc.size() == 0 && n < 60) begin step(0, 0, 1); n++; end
    if (fire_cyc.size() == 0) chk(tag, 1, 0);
  endtask

  initial begin
    int c, base;
    reset_n = 0; i_a_v = 0; i_a_d = '0; i_a_cnt = '0; i_flush = 0; i_z_r = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_z_v", o_z_v, 0); chk("rst_a_r", o_a_r, 0);
    chk("rst_z_last", o_z_last, 0); chk("rst_z_len", o_z_len, 0);
    @(posedge clk); #1; reset_n = 1;

    // two full bursts of 1..8 with one idle cycle between
    clear_log(); push_val = 1;
    for (int i = 0; i < 8; i++) step(1, 0, 1);
    drain();
    chk("t1_beats", fire_d.size(), 8);
    if (fire_d.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t1_data", fire_d[i], i + 1);
        chk("t1_last", fire_last[i], (i % 4 == 3) ? 1 : 0);
      end
      chk("t1_gap", fire_cyc[4] - fire_cyc[3], 2);
    end
    chk("t1_len", o_z_len, 4);

    // timeout release of a 2-entry partial burst
    step(0, 0, 1); step(0, 0, 1);
    clear_log(); c = cyc;
    step(2, 0, 1);
    wait_fire("t2_no_beat");
    if (fire_cyc.size() != 0) chk("t2_latency", fire_cyc[0] - c, T);
    drain();
    chk("t2_len", o_z_len, 2);
    chk("t2_beats", fire_d.size(), 2);
    if (fire_d.size() == 2) begin
      chk("t2_last0", fire_last[0], 0); chk("t2_last1", fire_last[1], 1);
    end
    chk("t2_qempty", q.size(), 0);

    // flush of a 3-entry partial burst
    clear_log();
    step(3, 0, 1); step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
    c = cyc;
    step(0, 1, 1);
    wait_fire("t3_no_beat");
    if (fire_cyc.size() != 0) chk("t3_latency", fire_cyc[0] - c, 1);
    drain();
    chk("t3_len", o_z_len, 3);
    chk("t3_beats", fire_d.size(), 3);

    // full burst with downstream ready toggling
    clear_log(); base = push_val;
    step(4, 0, 1);
    for (int k = 0; k < 12; k++) step(0, 0, (k % 2) == 0);
    chk("t4_beats", fire_d.size(), 4);
    if (fire_d.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t4_data", fire_d[i], (base + i) % 256);
        chk("t4_last", fire_last[i], (i == 3) ? 1 : 0);
      end
    chk("t4_last_held", last_stall, 1);
    drain();

    // count hits B together with flush and expired timeout: full burst wins
    step(0, 0, 1); step(0, 0, 1);
    clear_log();
    step(3, 0, 1);
    for (int k = 0; k < T-2; k++) step(0, 0, 1);
    step(1, 1, 1);
    wait_fire("t5_no_beat");
    chk("t5_len", o_z_len, 4);
    drain();
    chk("t5_beats", fire_d.size(), 4);
    clear_log(); c = cyc;
    step(1, 0, 1);
    wait_fire("t5_no_beat2");
    if (fire_cyc.size() != 0) chk("t5_wcnt_clear", fire_cyc[0] - c, T);
    drain();

    // reset in the middle of a full burst
    step(0, 0, 1);
    clear_log();
    step(4, 0, 1); step(0, 0, 1); step(0, 0, 1);
    chk("t6_pre_beats", fire_d.size(), 2);
    reset_n = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t6_rst_z_v", o_z_v, 0); chk("t6_rst_a_r", o_a_r, 0);
      chk("t6_rst_len", o_z_len, 0);
      @(posedge clk); #1; cyc++;
    end
    reset_n = 1;
    m_busy = 0; m_zlen = 0; m_wait = 0; m_left = 0;
    chk("t6_q_kept", q.size(), 2);
    step(0, 0, 1);
    chk("t6_idle_len", o_z_len, 0);
    drain();

    // randomized traffic
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 99) < 30) ? $urandom_range(1, 2) : 0,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 70);
    drain();
    chk("rand_all_out", rd_idx, pushed.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
